// File: rtl/prog_stream_loader.sv
// prog_stream_loader
//   Feeds the configuration chain. Config bytes arrive over a valid/ready
//   handshake and are shifted out LSB-first on prog_en/prog_in for exactly
//   CHAIN_LEN shift cycles. The bits displaced out of the chain (prog_out)
//   are folded into a CRC-8 readback signature.
//
// Ports
//   clk        : single clock, also the chain's prog_clk
//   rst        : asynchronous, active-high reset
//   start      : 1-cycle pulse, begins a load (honoured in IDLE or DONE)
//   abort      : level, cancels the load and returns to IDLE
//   byte_in    : config byte, bit 0 shifted first
//   byte_valid : byte_in valid
//   byte_ready : loader accepts byte_in this cycle
//   prog_en    : chain shift enable (registered)
//   prog_in    : chain serial data (registered)
//   prog_out   : chain serial output, sampled on every prog_en=1 cycle
//   busy       : loading (waiting for a byte or shifting)
//   done       : load complete, held until start, abort or rst
//   crc        : CRC-8 of the prog_out bits, valid when done=1
module prog_stream_loader #(
    parameter int          CHAIN_LEN = 128,
    parameter logic [7:0]  CRC_POLY  = 8'h07
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       prog_en,
    output logic       prog_in,
    input  logic       prog_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] crc
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [7:0]       sreg;      // bits of the current byte still to shift
    logic [3:0]       nbits;     // bits left in the current byte, incl. the one on prog_in
    logic [CNT_W-1:0] bitcnt;    // bits shifted since start
    logic [7:0]       crc_q;

    logic             load;
    logic             shift;
    logic             clear;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] load_cnt;
    logic [31:0]      remaining;
    logic [3:0]       nbits_load;
    logic             last_of_byte;
    logic             last_of_chain;
    logic             fb;
    logic [7:0]       crc_next;

    assign cnt_inc       = bitcnt + CNT_W'(1);
    assign last_of_byte  = (nbits == 4'd1);
    assign last_of_chain = (cnt_inc == CNT_W'(CHAIN_LEN));

    // A byte loaded back-to-back during SHIFT starts after the bit now on
    // prog_in, so its budget is measured from the incremented count.
    assign load_cnt   = (state == S_SHIFT) ? cnt_inc : bitcnt;
    assign remaining  = 32'(CHAIN_LEN) - 32'(load_cnt);
    assign nbits_load = (remaining >= 32'd8) ? 4'd8 : remaining[3:0];

    assign fb       = crc_q[7] ^ prog_out;
    assign crc_next = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);

    assign busy = (state == S_WAIT_BYTE) || (state == S_SHIFT);
    assign done = (state == S_DONE);
    assign crc  = crc_q;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        // Abort wins over start and over a handshake; byte_ready is held low
        // so the feeder never believes a dropped byte was taken.
        if (abort) begin
            state_next = S_IDLE;
            clear      = 1'b1;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_next = S_WAIT_BYTE;
                        clear      = 1'b1;
                    end
                end
                S_WAIT_BYTE: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        load       = 1'b1;
                        state_next = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift = 1'b1;
                    if (last_of_chain) begin
                        state_next = S_DONE;
                    end else if (last_of_byte) begin
                        byte_ready = 1'b1;
                        if (byte_valid) begin
                            load = 1'b1;
                        end else begin
                            state_next = S_WAIT_BYTE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            prog_en <= 1'b0;
            prog_in <= 1'b0;
            sreg    <= 8'h00;
            nbits   <= 4'd0;
            bitcnt  <= '0;
            crc_q   <= 8'h00;
        end else begin
            state   <= state_next;
            prog_en <= (state_next == S_SHIFT);
            if (clear) begin
                bitcnt <= '0;
                crc_q  <= 8'h00;
            end
            if (shift) begin
                bitcnt <= cnt_inc;
                crc_q  <= crc_next;
                nbits  <= nbits - 4'd1;
                // prog_in holds when the byte runs out, so it never moves
                // while prog_en is dropping.
                if (!last_of_byte) begin
                    prog_in <= sreg[0];
                    sreg    <= {1'b0, sreg[7:1]};
                end
            end
            // Placed after the shift update so a back-to-back load overrides it.
            if (load) begin
                prog_in <= byte_in[0];
                sreg    <= {1'b0, byte_in[7:1]};
                nbits   <= nbits_load;
            end
        end
    end

endmodule

// File: tb/tb_prog_stream_loader.sv
// tb_prog_stream_loader
//   Directed bench for prog_stream_loader. One instance with a 20-bit chain
//   covers streaming, stalls, abort, reset and ignored starts; one with an
//   8-bit chain covers the CRC readback and restart from DONE.
module tb_prog_stream_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 20-bit chain instance
    logic       start20 = 0, abort20 = 0, valid20 = 0, pout20 = 0;
    logic [7:0] data20 = 0;
    logic       ready20, en20, pin20, busy20, done20;
    logic [7:0] crc20;

    // 8-bit chain instance
    logic       start8 = 0, abort8 = 0, valid8 = 0, pout8 = 0;
    logic [7:0] data8 = 0;
    logic       ready8, en8, pin8, busy8, done8;
    logic [7:0] crc8;

    prog_stream_loader #(.CHAIN_LEN(20), .CRC_POLY(8'h07)) dut20 (
        .clk(clk), .rst(rst), .start(start20), .abort(abort20),
        .byte_in(data20), .byte_valid(valid20), .byte_ready(ready20),
        .prog_en(en20), .prog_in(pin20), .prog_out(pout20),
        .busy(busy20), .done(done20), .crc(crc20)
    );

    prog_stream_loader #(.CHAIN_LEN(8), .CRC_POLY(8'h07)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .byte_in(data8), .byte_valid(valid8), .byte_ready(ready8),
        .prog_en(en8), .prog_in(pin8), .prog_out(pout8),
        .busy(busy8), .done(done8), .crc(crc8)
    );

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected prog_in stream for bytes A5,3C,0F on a 20-bit chain (bit 0 first).
    logic [19:0] t1_bits = 20'b1111_0011_1100_1010_0101;

    // Shift-cycle monitor for the 20-bit instance: records every prog_in bit
    // seen with prog_en high.
    int   en_cnt = 0;
    logic seen_bits [0:511];
    always @(negedge clk) begin
        if (en20) begin
            if (en_cnt < 512) seen_bits[en_cnt] = pin20;
            en_cnt = en_cnt + 1;
        end
    end

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic [4:0] exp;   // {byte_ready, prog_en, prog_in (when en), busy, done}
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic s, input logic v, input logic [7:0] d, input logic [4:0] e);
        vec_t r;
        r.start = s; r.valid = v; r.data = d; r.exp = e;
        vecs.push_back(r);
    endtask

    task automatic pulse_start20();
        @(negedge clk); start20 = 1;
        @(negedge clk); start20 = 0;
    endtask

    // Waits for byte_ready with byte_valid low, keeps it low for 'gap' more
    // cycles (the chain must hold), then offers the byte.
    task automatic send_byte20(input logic [7:0] d, input int gap);
        bit found = 0;
        bit gap_ok = 1;
        valid20 = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #1;
            if (ready20) found = 1;
        end
        if (!found) begin
            check("ready_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); #1;
            if (en20 !== 1'b0 || ready20 !== 1'b1) gap_ok = 0;
        end
        if (gap > 0) check("gap_hold", 32'(gap_ok), 1);
        @(negedge clk); valid20 = 1; data20 = d;
        @(negedge clk); valid20 = 0;
    endtask

    task automatic wait_done20();
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk); #1;
            if (done20) found = 1;
        end
        check("done_timeout", 32'(found), 1);
    endtask

    // Full load of A5,3C,0F; optionally pulses start during the first byte.
    task automatic run_load(input string name, input int gap, input bit start_mid);
        int base;
        logic [19:0] got;
        base = en_cnt;
        pulse_start20();
        send_byte20(8'hA5, gap);
        if (start_mid) begin
            start20 = 1;
            @(negedge clk); start20 = 0;
        end
        send_byte20(8'h3C, gap);
        send_byte20(8'h0F, gap);
        wait_done20();
        got = '0;
        for (int i = 0; i < 20; i++) got[i] = seen_bits[base + i];
        check({name, "_en_cycles"}, 32'(en_cnt - base), 20);
        check({name, "_bits"}, 32'(got), 32'(t1_bits));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_dut20", {22'd0, ready20, en20, pin20, busy20, done20, crc20}, 0);
        check("reset_dut8",  {22'd0, ready8,  en8,  pin8,  busy8,  done8,  crc8},  0);
        rst = 0;

        // T1: back-to-back bytes, cycle-exact table
        add_vec(1, 0, 8'h00, 5'b00000);
        add_vec(0, 1, 8'hA5, 5'b10010);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic       r;
            d = (i < 8) ? 8'h3C : (i < 16) ? 8'h0F : 8'h77;
            r = (i == 7) || (i == 15);
            add_vec(0, 1, d, {r, 1'b1, t1_bits[i], 1'b1, 1'b0});
        end
        add_vec(0, 1, 8'h77, 5'b00001);
        add_vec(0, 0, 8'h00, 5'b00001);
        foreach (vecs[k]) begin
            logic [4:0] got;
            @(negedge clk);
            start20 = vecs[k].start; valid20 = vecs[k].valid; data20 = vecs[k].data;
            #1;
            got = {ready20, en20, en20 & pin20, busy20, done20};
            check($sformatf("t1_vec%0d", k), 32'(got), 32'(vecs[k].exp));
        end
        valid20 = 0;
        check("t1_crc_zero", 32'(crc20), 0);

        // T2: 5-cycle stalls before every byte
        run_load("t2", 5, 0);

        // T4: abort on the 3rd shift cycle with nonzero readback
        pout20 = 1;
        pulse_start20();
        @(negedge clk); valid20 = 1; data20 = 8'hFF;
        @(negedge clk); valid20 = 0;           // shift cycle 1
        @(negedge clk);                        // shift cycle 2
        @(negedge clk); #1;                    // shift cycle 3
        check("t4_shifting", {30'd0, en20, busy20}, 3);
        abort20 = 1;
        @(negedge clk); abort20 = 0; #1;
        check("t4_after_abort", {22'd0, ready20, en20, busy20, done20, 1'b0, crc20}, 0);
        pout20 = 0;
        run_load("t4_reload", 0, 0);

        // T6: start during SHIFT ignored
        run_load("t6_start_mid", 0, 1);

        // T5: async reset between edges mid-shift
        pulse_start20();
        @(negedge clk); valid20 = 1; data20 = 8'hA5;
        @(negedge clk); valid20 = 0;
        @(negedge clk); #1;
        check("t5_pre_rst_en", 32'(en20), 1);
        #1 rst = 1;
        #1;
        check("t5_rst_async", {28'd0, en20, ready20, done20, busy20}, 0);
        @(negedge clk); rst = 0;

        // T3: CRC readback on the 8-bit chain
        @(negedge clk); start8 = 1;
        @(negedge clk); start8 = 0; valid8 = 1; data8 = 8'h5A;
        #1 check("t3_ready", 32'(ready8), 1);
        @(negedge clk); valid8 = 0; pout8 = 1;
        @(negedge clk); pout8 = 0;
        begin
            bit found = 0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clk); #1;
                if (done8) found = 1;
            end
            check("t3_done_timeout", 32'(found), 1);
        end
        check("t3_crc_89", 32'(crc8), 32'h89);

        // T6: start in DONE clears done and crc, byte_ready next cycle
        @(negedge clk); start8 = 1;
        @(negedge clk); start8 = 0; #1;
        check("t6_restart", {23'd0, done8, crc8, ready8}, 1);

        // T3: all-zero readback
        @(negedge clk); valid8 = 1; data8 = 8'hC3;
        @(negedge clk); valid8 = 0;
        begin
            bit found = 0;
            for (int i = 0; i < 30 && !found; i++) begin
                @(negedge clk); #1;
                if (done8) found = 1;
            end
            check("t3z_done_timeout", 32'(found), 1);
        end
        check("t3_crc_00", 32'(crc8), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
